// File: rtl/mem_resp_pkg.sv
// Shared definitions for the mem_resp memory-bus responder: IO window
// register offsets, status-byte bit positions and the IO-select field.
package mem_resp_pkg;

  // Register offsets inside the IO window, relative to IO_BASE.
  localparam logic [15:0] IO_CHAR = 16'h0000;
  localparam logic [15:0] IO_CTRL = 16'h0004;

  // Bit positions within the status byte returned by the control register.
  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_OVF   = 2;

  // Address field that selects the IO window instead of RAM.
  localparam int         IO_SEL_HI  = 17;
  localparam int         IO_SEL_LO  = 16;
  localparam logic [1:0] IO_SEL_VAL = 2'b11;

  typedef enum logic [1:0] {
    IO_NONE     = 2'd0,
    IO_SEL_CHAR = 2'd1,
    IO_SEL_CTRL = 2'd2
  } io_reg_e;

  // Map the low 16 address bits of an IO access onto a register.
  function automatic io_reg_e io_decode(input logic [15:0] off,
                                        input logic [15:0] base);
    io_reg_e r;
    r = IO_NONE;
    if (off == base + IO_CHAR) begin
      r = IO_SEL_CHAR;
    end else if (off == base + IO_CTRL) begin
      r = IO_SEL_CTRL;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_resp_byte_fifo.sv
// Synchronous byte FIFO used as the character output queue.
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate counter. A pop in the same cycle as a push while full
// frees the slot the push needs, so that push is accepted.
module mem_resp_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] head,
  output logic       full,
  output logic       empty,
  output logic       accept
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wp_q, wp_d;
  logic [AW:0] rp_q, rp_d;
  logic [7:0]  store_q [DEPTH];
  logic        pop_ok;

  // Status flags and the push/pop qualification for this cycle.
  always_comb begin
    empty  = (wp_q == rp_q);
    full   = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    pop_ok = pop && !empty;
    accept = push && (!full || pop_ok);
    head   = store_q[rp_q[AW-1:0]];
  end

  // Next pointer values; both wrap naturally modulo 2*DEPTH.
  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (accept) begin
      wp_d = wp_q + {{AW{1'b0}}, 1'b1};
    end
    if (pop_ok) begin
      rp_d = rp_q + {{AW{1'b0}}, 1'b1};
    end
  end

  // Pointer registers; reset empties the queue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (accept) begin
      store_q[wp_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/mem_resp.sv
// mem_resp: responder end of the byte-serial CPU memory bus.
// Byte-wide RAM with one-cycle registered reads, plus an IO window
// (ad[17:16]==2'b11) holding a character-output FIFO and a halt register.
// Optional feature macro: MEM_PRELOAD_EN adds a host program-load port
// (ld_e/ld_a/ld_d) that writes RAM with priority over the CPU.
module mem_resp
  import mem_resp_pkg::*;
#(
  parameter int          ADDR_W     = 17,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] IO_BASE    = 32'h30000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       ad,
  input  logic              wr,
  input  logic [7:0]        din,
  output logic [7:0]        dout,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              halt,
  output logic              ovf
`ifdef MEM_PRELOAD_EN
  ,
  input  logic              ld_e,
  input  logic [ADDR_W-1:0] ld_a,
  input  logic [7:0]        ld_d
`endif
);

  // Address decode
  logic              io_sel;
  io_reg_e           io_reg;
  logic [ADDR_W-1:0] ram_idx;
  logic              char_push;
  logic              ctrl_wr;
  logic              unused_ad;

  // RAM
  logic [7:0]        mem_q [2**ADDR_W];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [7:0]        mem_wd;

  // Read path and control state
  logic [7:0]        status;
  logic [7:0]        io_rd;
  logic [7:0]        dout_q, dout_d;
  logic              ovf_q, ovf_d;
  logic              halt_req_q, halt_req_d;
  logic              halt_q, halt_d;

  // FIFO handshake
  logic [7:0]        fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_accept;
  logic              fifo_pop;

  // Upper address bits select nothing; RAM aliases across them.
  assign unused_ad = ^ad[31:18];

  // Split the bus address into IO register select or RAM index.
  always_comb begin
    io_sel    = (ad[IO_SEL_HI:IO_SEL_LO] == IO_SEL_VAL);
    io_reg    = io_sel ? io_decode(ad[15:0], IO_BASE[15:0]) : IO_NONE;
    ram_idx   = ad[ADDR_W-1:0];
    char_push = wr && (io_reg == IO_SEL_CHAR);
    ctrl_wr   = wr && (io_reg == IO_SEL_CTRL);
  end

  // Choose the single RAM writer for this cycle; host load wins over CPU.
  always_comb begin
    mem_we = wr && !io_sel;
    mem_wa = ram_idx;
    mem_wd = din;
`ifdef MEM_PRELOAD_EN
    if (ld_e) begin
      mem_we = 1'b1;
      mem_wa = ld_a;
      mem_wd = ld_d;
    end
`endif
  end

  // RAM array; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

  // Output character queue toward the host transmitter.
  mem_resp_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (char_push),
    .din    (din),
    .pop    (fifo_pop),
    .head   (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .accept (fifo_accept)
  );

  // Host handshake; tx_data is forced to zero while nothing is queued.
  always_comb begin
    tx_valid = !fifo_empty;
    tx_data  = fifo_empty ? 8'h00 : fifo_head;
    fifo_pop = tx_valid && tx_ready;
  end

  // IO read mux: only the control register returns non-zero data.
  always_comb begin
    status             = 8'h00;
    status[STAT_EMPTY] = fifo_empty;
    status[STAT_FULL]  = fifo_full;
    status[STAT_OVF]   = ovf_q;
    io_rd              = (io_reg == IO_SEL_CTRL) ? status : 8'h00;
  end

  // Next-state for read data and the sticky control flags.
  always_comb begin
    dout_d = dout_q;
    if (!wr) begin
      dout_d = io_sel ? io_rd : mem_q[ram_idx];
    end
    // A push rejected by the FIFO is a dropped character.
    ovf_d      = ovf_q || (char_push && !fifo_accept);
    halt_req_d = halt_req_q || ctrl_wr;
    // Halt waits until every queued character has left.
    halt_d     = halt_q || (halt_req_q && fifo_empty);
  end

  // Control and read-data registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_q     <= 8'h00;
      ovf_q      <= 1'b0;
      halt_req_q <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      dout_q     <= dout_d;
      ovf_q      <= ovf_d;
      halt_req_q <= halt_req_d;
      halt_q     <= halt_d;
    end
  end

  assign dout = dout_q;
  assign halt = halt_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_mem_resp.sv
// Self-checking bench for mem_resp: directed scenarios plus a randomized
// phase, all compared against a queue/array reference model.
module tb_mem_resp;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ad;
  logic        wr;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        halt;
  logic        ovf;

  always #5 clk = ~clk;

  mem_resp #(
    .ADDR_W     (17),
    .FIFO_DEPTH (DEPTH),
    .IO_BASE    (32'h30000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ad       (ad),
    .wr       (wr),
    .din      (din),
    .dout     (dout),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .halt     (halt),
    .ovf      (ovf)
`ifdef MEM_PRELOAD_EN
    ,
    .ld_e     (1'b0),
    .ld_a     (17'd0),
    .ld_d     (8'h00)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  logic [7:0] m_q [$];
  logic [7:0] m_ram [int unsigned];
  bit         m_ovf;
  bit         m_hreq;
  bit         m_halt;
  logic [7:0] m_dout;
  bit         m_dout_known;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf        = 0;
    m_hreq       = 0;
    m_halt       = 0;
    m_dout       = 8'h00;
    m_dout_known = 1;
  endtask

  task automatic cmp_model();
    if (m_dout_known) check("dout", dout, m_dout);
    check("tx_valid", tx_valid, m_q.size() > 0);
    check("tx_data", tx_data, (m_q.size() > 0) ? m_q[0] : 8'h00);
    check("halt", halt, m_halt);
    check("ovf", ovf, m_ovf);
  endtask

  // One bus cycle: compare, drive, advance the model, step to next negedge.
  task automatic cyc(input logic [31:0] a, input logic w, input logic [7:0] d, input logic rdy);
    bit io, chr, ctl, pop;
    int unsigned idx;
    cmp_model();
    ad = a; wr = w; din = d; tx_ready = rdy;
    io  = (a[17:16] == 2'b11);
    chr = io && (a[15:0] == 16'h0000);
    ctl = io && (a[15:0] == 16'h0004);
    idx = a[16:0];
    pop = rdy && (m_q.size() > 0);
    if (!w) begin
      if (io) begin
        m_dout = ctl ? {5'b0, m_ovf, m_q.size() == DEPTH, m_q.size() == 0} : 8'h00;
        m_dout_known = 1;
      end else if (m_ram.exists(idx)) begin
        m_dout = m_ram[idx];
        m_dout_known = 1;
      end else begin
        m_dout_known = 0;
      end
    end
    if (w && !io) m_ram[idx] = d;
    m_halt = m_halt || (m_hreq && m_q.size() == 0);
    if (w && ctl) m_hreq = 1;
    if (pop) void'(m_q.pop_front());
    if (w && chr) begin
      if (m_q.size() < DEPTH) m_q.push_back(d);
      else m_ovf = 1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic logic [31:0] rand_ram_addr();
    logic [31:0] a;
    a = $urandom();
    a[16]   = 1'b0;
    a[15:0] = 16'h0180 + 16'($urandom_range(0, 31));
    return a;
  endfunction

  logic [7:0] vals [4];

  initial begin
    rst = 1'b0; ad = '0; wr = 1'b0; din = '0; tx_ready = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    cmp_model();
    rst = 1'b1;

    // Write then read one byte
    cyc(32'h100, 1, 8'hA5, 0);
    cyc(32'h100, 0, 8'h00, 0);
    check("rd_a5", dout, 8'hA5);

    // Streaming reads, one byte per cycle
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    for (int i = 0; i < 4; i++) cyc(32'h200 + i, 1, vals[i], 0);
    for (int i = 0; i < 4; i++) begin
      cyc(32'h200 + i, 0, 8'h00, 0);
      check($sformatf("stream%0d", i), dout, vals[i]);
    end

    // Overflow: nine pushes into an 8-entry queue
    do_reset();
    for (int i = 0; i < 9; i++) cyc(32'h30000, 1, 8'h40 + 8'(i), 0);
    check("ovf_set", ovf, 1'b1);
    cyc(32'h30004, 0, 8'h00, 0);
    check("status_ovf_full", dout, 8'h06);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain_vld%0d", i), tx_valid, 1'b1);
      check($sformatf("drain_dat%0d", i), tx_data, 8'h40 + 8'(i));
      cyc(32'h100, 0, 8'h00, 1);
    end
    check("drained", tx_valid, 1'b0);

    // Push while full with a simultaneous pop
    do_reset();
    for (int i = 0; i < 8; i++) cyc(32'h30000, 1, 8'h60 + 8'(i), 0);
    cyc(32'h30000, 1, 8'h77, 1);
    check("full_push_ovf", ovf, 1'b0);
    cyc(32'h30004, 0, 8'h00, 0);
    check("status_full", dout, 8'h02);
    for (int i = 0; i < 9; i++) cyc(32'h100, 0, 8'h00, 1);

    // Halt waits for the queue to drain
    do_reset();
    for (int i = 0; i < 3; i++) cyc(32'h30000, 1, 8'h31 + 8'(i), 0);
    cyc(32'h30004, 1, 8'h5A, 0);
    for (int i = 0; i < 3; i++) cyc(32'h100, 0, 8'h00, 0);
    check("halt_blocked", halt, 1'b0);
    for (int i = 0; i < 3; i++) cyc(32'h100, 0, 8'h00, 1);
    check("halt_pre", halt, 1'b0);
    cyc(32'h100, 0, 8'h00, 1);
    check("halt_rise", halt, 1'b1);
    for (int i = 0; i < 3; i++) cyc(32'h30000, 1, 8'h99, 0);
    check("halt_sticky", halt, 1'b1);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 32; i++) cyc(rand_ram_addr(), 1, 8'($urandom()), 0);
    for (int i = 0; i < 800; i++) begin
      int k;
      logic [31:0] a;
      k = $urandom_range(0, 39);
      if (k < 24) begin
        a = rand_ram_addr();
      end else if (k < 34) begin
        a = 32'h30000;
      end else if (k == 34) begin
        a = 32'h30004;
        if ($urandom_range(0, 3) != 0) a = 32'h30004 | 32'h1;
      end else if (k < 38) begin
        a = 32'h30004;
      end else begin
        a = {$urandom_range(0, 16383), 2'b11, 16'($urandom_range(8, 16'hFFFF))};
      end
      if (k == 37 && $urandom_range(0, 9) != 0) a = rand_ram_addr();
      cyc(a, 1'($urandom_range(0, 1)), 8'($urandom()), 1'($urandom_range(0, 2) != 0));
    end

    // Asynchronous reset in the middle of a drain
    do_reset();
    for (int i = 0; i < 9; i++) cyc(32'h30000, 1, 8'h80 + 8'(i), 0);
    for (int i = 0; i < 4; i++) cyc(32'h100, 0, 8'h00, 1);
    cyc(32'h100, 0, 8'h00, 0);
    check("pre_rst_vld", tx_valid, 1'b1);
    check("pre_rst_ovf", ovf, 1'b1);
    check("pre_rst_dout", dout, 8'hA5);
    tx_ready = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_halt", halt, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_dout", dout, 8'h00);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    cyc(32'h100, 0, 8'h00, 0);
    check("ram_kept", dout, 8'hA5);
    cyc(32'h100, 0, 8'h00, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
